// File: rtl/il_alu_exec_pkg.sv
// Shared opcode and FSM-state encodings for the IL ALU execute stage.
// Imported by the execute stage and by anything that decodes its opcodes.
package il_alu_exec_pkg;

    localparam int ALU_OP_LEN = 4;

    typedef enum logic [ALU_OP_LEN-1:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_ADD = 4'd6,
        OP_SUB = 4'd7,
        OP_GT  = 4'd8,
        OP_GE  = 4'd9,
        OP_EQ  = 4'd10,
        OP_LT  = 4'd11,
        OP_MUL = 4'd12,
        OP_ST  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/il_alu_mul_seq.sv
// Shift-add multiplier datapath: one partial-product step per cycle, MUL_CYCLES steps per product.
// done is high during the final step; product holds its value until the next start.
module il_alu_mul_seq #(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic                  abort,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_prod;
    logic [CNT_W-1:0]    r_count;
    logic                r_busy;
    logic                w_last;

    assign w_last  = r_busy && (r_count == LAST_CNT);
    assign done    = w_last;
    assign product = r_prod;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (abort) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (start) begin
            r_mcand  <= {{DATA_W{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_prod   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= w_last ? '0 : r_count + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/il_alu_exec.sv
// IL execute stage: updates the accumulator ("current result"), carry and zero flags from the
// selected operand. Single-cycle logic/arith/compare ops; multiply runs on il_alu_mul_seq.
module il_alu_exec
    import il_alu_exec_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OP_W       = ALU_OP_LEN,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [OP_W-1:0]   aluOp,
    input  logic [DATA_W-1:0] op2In,
    input  logic              flush,
    output logic [DATA_W-1:0] accOut,
    output logic              carryOut,
    output logic              zeroOut,
    output logic              resultValid,
    output logic [DATA_W-1:0] storeData,
    output logic              storeEn
);

    alu_state_e r_state, w_state_nxt;

    logic [DATA_W-1:0]   r_acc;
    logic                r_carry;
    logic                r_zero;
    logic                r_result_valid;
    logic                r_store_en;
    logic [DATA_W-1:0]   r_store_data;

    alu_op_e             w_op;
    logic                w_accept;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic                w_carry_nxt;
    logic                w_write;
    logic                w_store;
    logic                w_is_mul;
    logic                w_mul_start;
    logic                w_mul_abort;
    logic                w_mul_done;
    logic                w_mul_commit;
    logic [2*DATA_W-1:0] w_product;

    assign w_op     = alu_op_e'(aluOp);
    assign inReady  = (r_state == ST_IDLE);
    assign w_accept = inValid & inReady & ~flush;

    // Bit DATA_W of the difference is the borrow (acc < op2 unsigned).
    assign w_sum  = {1'b0, r_acc} + {1'b0, op2In};
    assign w_diff = {1'b0, r_acc} - {1'b0, op2In};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_write     = 1'b0;
        w_store     = 1'b0;
        w_is_mul    = 1'b0;
        case (w_op)
            OP_LD:  begin w_acc_nxt = op2In;          w_write = 1'b1; end
            OP_AND: begin w_acc_nxt = r_acc & op2In;  w_write = 1'b1; end
            OP_OR:  begin w_acc_nxt = r_acc | op2In;  w_write = 1'b1; end
            OP_XOR: begin w_acc_nxt = r_acc ^ op2In;  w_write = 1'b1; end
            OP_NOT: begin w_acc_nxt = ~r_acc;         w_write = 1'b1; end
            OP_ADD: begin
                {w_carry_nxt, w_acc_nxt} = w_sum;
                w_write = 1'b1;
            end
            OP_SUB: begin
                {w_carry_nxt, w_acc_nxt} = w_diff;
                w_write = 1'b1;
            end
            OP_GT: begin w_acc_nxt = {{(DATA_W-1){1'b0}}, r_acc >  op2In}; w_write = 1'b1; end
            OP_GE: begin w_acc_nxt = {{(DATA_W-1){1'b0}}, r_acc >= op2In}; w_write = 1'b1; end
            OP_EQ: begin w_acc_nxt = {{(DATA_W-1){1'b0}}, r_acc == op2In}; w_write = 1'b1; end
            OP_LT: begin w_acc_nxt = {{(DATA_W-1){1'b0}}, r_acc <  op2In}; w_write = 1'b1; end
            OP_MUL: w_is_mul = 1'b1;
            OP_ST:  w_store  = 1'b1;
            default: ;
        endcase
    end

    assign w_mul_start  = w_accept & w_is_mul;
    assign w_mul_abort  = flush & (r_state != ST_IDLE);
    assign w_mul_commit = (r_state == ST_DONE) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
            ST_MUL: begin
                if (flush)           w_state_nxt = ST_IDLE;
                else if (w_mul_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc          <= '0;
            r_carry        <= 1'b0;
            r_zero         <= 1'b1;
            r_result_valid <= 1'b0;
            r_store_en     <= 1'b0;
            r_store_data   <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_store_en     <= 1'b0;
            if (w_accept) begin
                if (w_write) begin
                    r_acc  <= w_acc_nxt;
                    r_zero <= (w_acc_nxt == '0);
                end
                r_carry <= w_carry_nxt;
                if (w_store) begin
                    r_store_data <= r_acc;
                    r_store_en   <= 1'b1;
                end
                r_result_valid <= w_write | w_store;
            end else if (w_mul_commit) begin
                r_acc          <= w_product[DATA_W-1:0];
                r_carry        <= |w_product[2*DATA_W-1:DATA_W];
                r_zero         <= (w_product[DATA_W-1:0] == '0);
                r_result_valid <= 1'b1;
            end
        end
    end

    il_alu_mul_seq #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .clk          (clk),
        .reset        (reset),
        .start        (w_mul_start),
        .multiplicand (r_acc),
        .multiplier   (op2In),
        .abort        (w_mul_abort),
        .done         (w_mul_done),
        .product      (w_product)
    );

    assign accOut      = r_acc;
    assign carryOut    = r_carry;
    assign zeroOut     = r_zero;
    assign resultValid = r_result_valid;
    assign storeData   = r_store_data;
    assign storeEn     = r_store_en;

endmodule

// File: tb/tb_il_alu_exec.sv
// Self-checking bench for il_alu_exec: directed vector table, multiply/flush/reset sequences,
// then random ops compared against a plain-arithmetic accumulator model.
module tb_il_alu_exec;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [3:0] aluOp;
    logic [7:0] op2In;
    logic       flush;
    logic [7:0] accOut;
    logic       carryOut;
    logic       zeroOut;
    logic       resultValid;
    logic [7:0] storeData;
    logic       storeEn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_acc;
    logic       m_carry;
    logic       m_zero;

    typedef struct {
        logic [3:0] op;
        logic [7:0] op2;
        logic [7:0] acc;
        logic       carry;
        logic       zero;
        logic       rv;
        logic       st;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    il_alu_exec #(
        .DATA_W     (8),
        .OP_W       (4),
        .MUL_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .aluOp       (aluOp),
        .op2In       (op2In),
        .flush       (flush),
        .accOut      (accOut),
        .carryOut    (carryOut),
        .zeroOut     (zeroOut),
        .resultValid (resultValid),
        .storeData   (storeData),
        .storeEn     (storeEn)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 8'h00;
        m_carry = 1'b0;
        m_zero  = 1'b1;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [7:0] b,
                              output logic rv, output logic st);
        int s;
        logic [7:0] a;
        a  = m_acc;
        rv = 1'b1;
        st = 1'b0;
        case (op)
            4'd1:  m_acc = b;
            4'd2:  m_acc = a & b;
            4'd3:  m_acc = a | b;
            4'd4:  m_acc = a ^ b;
            4'd5:  m_acc = ~a;
            4'd6:  begin s = int'(a) + int'(b); m_acc = 8'(s); m_carry = (s > 255); end
            4'd7:  begin s = int'(a) - int'(b) + 256; m_acc = 8'(s); m_carry = (a < b); end
            4'd8:  m_acc = (a >  b) ? 8'd1 : 8'd0;
            4'd9:  m_acc = (a >= b) ? 8'd1 : 8'd0;
            4'd10: m_acc = (a == b) ? 8'd1 : 8'd0;
            4'd11: m_acc = (a <  b) ? 8'd1 : 8'd0;
            4'd12: begin s = int'(a) * int'(b); m_acc = 8'(s); m_carry = (s > 255); end
            4'd13: st = 1'b1;
            default: rv = 1'b0;
        endcase
        m_zero = (m_acc == 8'h00);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_acc"},   16'(accOut),   16'(m_acc));
        check({tag, "_carry"}, 16'(carryOut), 16'(m_carry));
        check({tag, "_zero"},  16'(zeroOut),  16'(m_zero));
    endtask

    // Called at a negedge; returns at the negedge after the issuing edge.
    task automatic drive_op(input logic [3:0] op, input logic [7:0] b, input logic fl);
        inValid = 1'b1;
        aluOp   = op;
        op2In   = b;
        flush   = fl;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        flush   = 1'b0;
        aluOp   = 4'd0;
    endtask

    task automatic single_op(input logic [3:0] op, input logic [7:0] b, input logic fl);
        logic rv_e, st_e;
        drive_op(op, b, fl);
        if (fl) begin
            rv_e = 1'b0;
            st_e = 1'b0;
        end else begin
            model_step(op, b, rv_e, st_e);
        end
        check($sformatf("op%0d_rv", op), 16'(resultValid), 16'(rv_e));
        check($sformatf("op%0d_st", op), 16'(storeEn), 16'(st_e));
        if (st_e) check("st_data", 16'(storeData), 16'(m_acc));
        check(fl ? "flushed" : "single", 16'(inReady), 16'd1);
        check_model(fl ? "flushed" : "single");
    endtask

    // flush_at = 0: no flush; k>0: flush driven for the edge ending the k-th busy cycle.
    task automatic do_mul(input logic [7:0] b, input logic junk, input int flush_at);
        int   low;
        logic saw_rv, rv_e, st_e;
        inValid = 1'b1;
        aluOp   = 4'd12;
        op2In   = b;
        flush   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        aluOp   = 4'd0;
        low     = 0;
        saw_rv  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (inReady) break;
            low++;
            if (resultValid) saw_rv = 1'b1;
            if (junk) begin
                inValid = 1'b1;
                aluOp   = 4'd1;
                op2In   = 8'($urandom);
            end
            if (k == flush_at) flush = 1'b1;
            @(posedge clk);
            @(negedge clk);
            inValid = 1'b0;
            flush   = 1'b0;
        end
        check("mul_busy_cycles", 16'(low), 16'((flush_at == 0) ? 9 : flush_at));
        check("mul_no_early_rv", 16'(saw_rv), 16'd0);
        if (flush_at == 0) begin
            model_step(4'd12, b, rv_e, st_e);
            check("mul_rv", 16'(resultValid), 16'd1);
        end else begin
            check("mul_abort_rv", 16'(resultValid), 16'd0);
        end
        check("mul_st", 16'(storeEn), 16'd0);
        check_model("mul");
    endtask

    task automatic idle_cycle();
        inValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_rv", 16'(resultValid), 16'd0);
        check("idle_st", 16'(storeEn), 16'd0);
        check_model("idle");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic rv_d, st_d;
        logic [3:0] rop;
        int sel;

        reset   = 1'b0;
        inValid = 1'b0;
        flush   = 1'b0;
        aluOp   = 4'd0;
        op2In   = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_acc",   16'(accOut),      16'h00);
        check("rst_carry", 16'(carryOut),    16'd0);
        check("rst_zero",  16'(zeroOut),     16'd1);
        check("rst_rv",    16'(resultValid), 16'd0);
        check("rst_st",    16'(storeEn),     16'd0);
        check("rst_sd",    16'(storeData),   16'h00);
        check("rst_ready", 16'(inReady),     16'd1);
        reset = 1'b1;

        //               op     op2     acc    c     z     rv    st
        vecs.push_back('{4'd1,  8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd6,  8'hB0, 8'h0A, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd1,  8'h03, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd7,  8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd10, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd8,  8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd11, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'd9,  8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd6,  8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd1,  8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd2,  8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd3,  8'h05, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd4,  8'hFF, 8'hCA, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd5,  8'h00, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd1,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd13, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{4'd5,  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'd15, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'd0,  8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'd7,  8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'd6,  8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'd9,  8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'd14, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{4'd1,  8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            drive_op(vecs[i].op, vecs[i].op2, 1'b0);
            model_step(vecs[i].op, vecs[i].op2, rv_d, st_d);
            check($sformatf("vec%0d_acc", i),   16'(accOut),      16'(vecs[i].acc));
            check($sformatf("vec%0d_carry", i), 16'(carryOut),    16'(vecs[i].carry));
            check($sformatf("vec%0d_zero", i),  16'(zeroOut),     16'(vecs[i].zero));
            check($sformatf("vec%0d_rv", i),    16'(resultValid), 16'(vecs[i].rv));
            check($sformatf("vec%0d_st", i),    16'(storeEn),     16'(vecs[i].st));
            if (vecs[i].st) check($sformatf("vec%0d_sd", i), 16'(storeData), 16'(vecs[i].acc));
        end
        idle_cycle();

        // Multiply, with junk ops presented while busy, then overflowing multiply.
        single_op(4'd1, 8'h0C, 1'b0);
        do_mul(8'h0B, 1'b1, 0);
        check("mul1_acc_const",   16'(accOut),   16'h84);
        check("mul1_carry_const", 16'(carryOut), 16'd0);
        idle_cycle();
        do_mul(8'h20, 1'b0, 0);
        check("mul2_acc_const",   16'(accOut),   16'h80);
        check("mul2_carry_const", 16'(carryOut), 16'd1);

        // Flush mid-multiply and during the write-back cycle.
        single_op(4'd1, 8'h10, 1'b0);
        do_mul(8'h10, 1'b0, 3);
        check("flush_mul_acc_const", 16'(accOut), 16'h10);
        idle_cycle();
        do_mul(8'h10, 1'b1, 9);
        idle_cycle();
        single_op(4'd12, 8'h02, 1'b1);
        idle_cycle();

        // Asynchronous reset in the middle of a multiply.
        single_op(4'd1, 8'h07, 1'b0);
        inValid = 1'b1;
        aluOp   = 4'd12;
        op2In   = 8'h03;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_acc",   16'(accOut),      16'h00);
        check("arst_carry", 16'(carryOut),    16'd0);
        check("arst_zero",  16'(zeroOut),     16'd1);
        check("arst_rv",    16'(resultValid), 16'd0);
        check("arst_ready", 16'(inReady),     16'd1);
        @(negedge clk);
        reset = 1'b1;
        single_op(4'd1, 8'h42, 1'b0);
        check("post_rst_ld_const", 16'(accOut), 16'h42);
        idle_cycle();

        // Random traffic against the model.
        repeat (250) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: idle_cycle();
                1: single_op(4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
                2: do_mul(8'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0);
                default: begin
                    rop = 4'($urandom_range(0, 15));
                    if (rop == 4'd12) rop = 4'd1;
                    single_op(rop, 8'($urandom), 1'b0);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
